// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a single-port data memory: handshakes one
// request at a time, splits boundary-crossing accesses into two beats and extends load data.
module lsu_mem_port #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter bit          MISALIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_mask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic              store_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic              split_q;
    logic [ADDR_W-1:0] b1_addr;
    logic [NB-1:0]     b1_mask;
    logic [XLEN-1:0]   b1_data;
    logic [XLEN-1:0]   rd0_q;
    logic              b1_first;

    function automatic logic legal_f(input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (st) begin
            ok = !f3[2] && ((f3[1:0] != 2'b11) || (XLEN == 64));
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                3'b011, 3'b110:                          ok = (XLEN == 64);
                default:                                 ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Request decode, only ever sampled into registers on accept
    logic [3:0]          size_b;
    logic [OFF_W-1:0]    off;
    logic                split_c;
    logic                misal_c;
    logic                err_c;
    logic                accept;
    logic [XLEN-1:0]     wdata_m;
    logic [2*XLEN-1:0]   wide;
    logic [2*NB-1:0]     wide_mask;
    logic [ADDR_W-1:0]   beat0_addr;

    assign size_b     = 4'd1 << req_funct3[1:0];
    assign off        = req_addr[OFF_W-1:0];
    assign split_c    = (5'(off) + 5'(size_b)) > 5'(NB);
    assign misal_c    = |(4'(req_addr) & (size_b - 4'd1));
    assign err_c      = !legal_f(req_store, req_funct3) || (!MISALIGNED_EN && misal_c);
    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign wdata_m    = req_wdata & ~({XLEN{1'b1}} << {size_b, 3'b000});
    assign wide       = {{XLEN{1'b0}}, wdata_m} << {off, 3'b000};
    assign wide_mask  = ~({(2*NB){1'b1}} << size_b) << off;
    assign beat0_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Load alignment and extension from the latched request
    logic [3:0]        size_q_b;
    logic [6:0]        nbits_q;
    logic [XLEN-1:0]   keep;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   lo;
    logic              sign;
    logic [XLEN-1:0]   ext;

    assign size_q_b = 4'd1 << f3_q[1:0];
    assign nbits_q  = {size_q_b, 3'b000};
    assign keep     = ~({XLEN{1'b1}} << nbits_q);
    assign cat      = split_q ? {mem_rdata, rd0_q} : {{XLEN{1'b0}}, mem_rdata};
    assign lo       = XLEN'(cat >> {off_q, 3'b000});
    assign sign     = |(lo & (keep ^ (keep >> 1)));
    assign ext      = (lo & keep) | ((sign && !f3_q[2]) ? ~keep : {XLEN{1'b0}});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid) state_nxt = err_c ? RESP : BEAT0;
            BEAT0: if (mem_ready) begin
                       if (split_q)      state_nxt = BEAT1;
                       else if (store_q) state_nxt = RESP;
                       else              state_nxt = WAIT;
                   end
            BEAT1: if (mem_ready) state_nxt = store_q ? RESP : WAIT;
            WAIT:  state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat outputs are loaded ahead of the state that presents them and held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_cs    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= '0;
            mem_mask  <= '0;
            mem_wdata <= '0;
            store_q   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            split_q   <= 1'b0;
            b1_addr   <= '0;
            b1_mask   <= '0;
            b1_data   <= '0;
            rd0_q     <= '0;
            b1_first  <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == RESP);
            rsp_err   <= accept && err_c;
            rsp_rdata <= (state == WAIT) ? ext : '0;
            mem_cs    <= !((state_nxt == BEAT0) || (state_nxt == BEAT1));
            b1_first  <= (state == BEAT0) && mem_ready && split_q;
            if (accept) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                off_q   <= off;
                split_q <= split_c;
                b1_addr <= beat0_addr + ADDR_W'(NB);
                b1_mask <= req_store ? wide_mask[2*NB-1:NB] : {NB{1'b1}};
                b1_data <= req_store ? wide[2*XLEN-1:XLEN] : '0;
                if (!err_c) begin
                    mem_addr  <= beat0_addr;
                    mem_wr    <= !req_store;
                    mem_mask  <= req_store ? wide_mask[NB-1:0] : {NB{1'b1}};
                    mem_wdata <= req_store ? wide[XLEN-1:0] : '0;
                end
            end
            if ((state == BEAT0) && mem_ready && split_q) begin
                mem_addr  <= b1_addr;
                mem_mask  <= b1_mask;
                mem_wdata <= b1_data;
            end
            if ((state == BEAT1) && b1_first) rd0_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a 32-bit split-capable unit and a 64-bit
// unit with misalignment reported as error, each with its own memory model.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Unit A: XLEN 32, split enabled
    logic        rv_a = 0, rr_a, st_a = 0, vl_a, er_a, cs_a, wr_a, my_a = 1;
    logic [2:0]  f3_a = 0;
    logic [31:0] ad_a = 0, wd_a = 0, rd_a, ma_a, mw_a, mr_a;
    logic [3:0]  mk_a;
    // Unit B: XLEN 64, misalignment is an error
    logic        rv_b = 0, rr_b, st_b = 0, vl_b, er_b, cs_b, wr_b, my_b = 1;
    logic [2:0]  f3_b = 0;
    logic [31:0] ad_b = 0, ma_b;
    logic [63:0] wd_b = 0, rd_b, mw_b, mr_b;
    logic [7:0]  mk_b;

    lsu_mem_port #(.XLEN(32), .ADDR_W(32), .MISALIGNED_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rr_a), .req_store(st_a),
        .req_funct3(f3_a), .req_addr(ad_a), .req_wdata(wd_a), .rsp_valid(vl_a),
        .rsp_rdata(rd_a), .rsp_err(er_a), .mem_cs(cs_a), .mem_wr(wr_a), .mem_addr(ma_a),
        .mem_mask(mk_a), .mem_wdata(mw_a), .mem_ready(my_a), .mem_rdata(mr_a));

    lsu_mem_port #(.XLEN(64), .ADDR_W(32), .MISALIGNED_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rr_b), .req_store(st_b),
        .req_funct3(f3_b), .req_addr(ad_b), .req_wdata(wd_b), .rsp_valid(vl_b),
        .rsp_rdata(rd_b), .rsp_err(er_b), .mem_cs(cs_b), .mem_wr(wr_b), .mem_addr(ma_b),
        .mem_mask(mk_b), .mem_wdata(mw_b), .mem_ready(my_b), .mem_rdata(mr_b));

    logic [63:0] mem_a [bit [31:0]];
    logic [63:0] mem_b [bit [31:0]];

    // Read data valid only in the cycle after an accepted read beat
    always @(posedge clk) begin
        mr_a <= (!cs_a && wr_a && my_a) ? 32'(mem_a[ma_a]) : 32'hDEAD_DEAD;
        mr_b <= (!cs_b && wr_b && my_b) ? mem_b[ma_b] : 64'hDEAD_DEAD_DEAD_DEAD;
    end

    typedef struct { logic [31:0] addr; logic wr; logic [7:0] mask; logic [63:0] wdata; } beat_t;
    typedef struct { logic [63:0] rdata; logic err; int due; } rsp_t;

    beat_t qb_a[$], qb_b[$];
    rsp_t  qr_a[$], qr_b[$];

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endfunction

    function automatic void flag(input string n);
        checks++;
        errors++;
        $display("FAIL %s actual=none expected=event", n);
    endfunction

    function automatic void eb(input int inst, input logic [31:0] a, input logic w,
                               input logic [7:0] m, input logic [63:0] d);
        beat_t b;
        b = '{a, w, m, d};
        if (inst == 0) qb_a.push_back(b);
        else           qb_b.push_back(b);
    endfunction

    // Monitor: compare every presented beat and every response against the queues
    rsp_t ra, rb;
    always @(negedge clk) begin
        if (!cs_a) begin
            if (qb_a.size() == 0) flag("beat_a_unexpected");
            else begin
                chk("beat_a_addr", 64'(ma_a), 64'(qb_a[0].addr));
                chk("beat_a_wr", 64'(wr_a), 64'(qb_a[0].wr));
                chk("beat_a_mask", 64'(mk_a), 64'(qb_a[0].mask));
                chk("beat_a_wdata", 64'(mw_a), qb_a[0].wdata);
                if (my_a) void'(qb_a.pop_front());
            end
        end
        if (vl_a) begin
            if (qr_a.size() == 0) flag("rsp_a_unexpected");
            else begin
                ra = qr_a.pop_front();
                chk("rsp_a_rdata", 64'(rd_a), ra.rdata);
                chk("rsp_a_err", 64'(er_a), 64'(ra.err));
                chk("rsp_a_cycle", 64'(cyc), 64'(ra.due));
            end
        end
        if (!cs_b) begin
            if (qb_b.size() == 0) flag("beat_b_unexpected");
            else begin
                chk("beat_b_addr", 64'(ma_b), 64'(qb_b[0].addr));
                chk("beat_b_wr", 64'(wr_b), 64'(qb_b[0].wr));
                chk("beat_b_mask", 64'(mk_b), 64'(qb_b[0].mask));
                chk("beat_b_wdata", mw_b, qb_b[0].wdata);
                if (my_b) void'(qb_b.pop_front());
            end
        end
        if (vl_b) begin
            if (qr_b.size() == 0) flag("rsp_b_unexpected");
            else begin
                rb = qr_b.pop_front();
                chk("rsp_b_rdata", rd_b, rb.rdata);
                chk("rsp_b_err", 64'(er_b), 64'(rb.err));
                chk("rsp_b_cycle", 64'(cyc), 64'(rb.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after accept.
    // lat < 0 means no response is expected.
    task automatic issue(input int inst, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] er, input logic ee, input int lat);
        rsp_t r;
        bit   done;
        done = 1'b0;
        if (inst == 0) begin
            st_a = st; f3_a = f3; ad_a = addr; wd_a = wd[31:0]; rv_a = 1'b1;
        end else begin
            st_b = st; f3_b = f3; ad_b = addr; wd_b = wd; rv_b = 1'b1;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            if ((inst == 0) ? rr_a : rr_b) begin
                r.rdata = er;
                r.err   = ee;
                r.due   = cyc + lat;
                if (lat >= 0) begin
                    if (inst == 0) qr_a.push_back(r);
                    else           qr_b.push_back(r);
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        rv_a = 1'b0;
        rv_b = 1'b0;
        if (!done) flag("issue_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (qb_a.size() + qb_b.size() + qr_a.size() + qr_b.size() == 0) break;
            @(negedge clk);
        end
        if (qb_a.size() + qb_b.size() + qr_a.size() + qr_b.size() != 0) begin
            flag("drain_timeout");
            qb_a.delete(); qb_b.delete(); qr_a.delete(); qr_b.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_a[32'h100] = 64'h80FF_1234;
        mem_a[32'h104] = 64'h4433_2211;
        mem_a[32'h108] = 64'h8877_6655;
        mem_b[32'h0]   = 64'hF000_0001_DEAD_BEEF;

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(rr_a), 64'd0);
        chk("rst_rsp_valid", 64'(vl_a), 64'd0);
        chk("rst_rsp_rdata", 64'(rd_a), 64'd0);
        chk("rst_rsp_err", 64'(er_a), 64'd0);
        chk("rst_cs", 64'(cs_a), 64'd1);
        chk("rst_wr", 64'(wr_a), 64'd1);
        chk("rst_addr", 64'(ma_a), 64'd0);
        chk("rst_mask", 64'(mk_a), 64'd0);
        chk("rst_wdata", 64'(mw_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(rr_a), 64'd1);

        // XLEN 32: loads of every width, back-to-back pair first
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b000, 32'h103, 64'd0, 64'hFFFF_FF80, 1'b0, 3);
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b100, 32'h103, 64'd0, 64'h0000_0080, 1'b0, 3);
        drain();
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b001, 32'h102, 64'd0, 64'hFFFF_80FF, 1'b0, 3);
        drain();
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b101, 32'h100, 64'd0, 64'h0000_1234, 1'b0, 3);
        drain();
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b001, 32'h101, 64'd0, 64'hFFFF_FF12, 1'b0, 3);
        drain();

        // Aligned store
        eb(0, 32'h200, 1'b0, 8'h0C, 64'hABCD_0000);
        issue(0, 1'b1, 3'b001, 32'h202, 64'h0000_ABCD, 64'd0, 1'b0, 2);
        drain();

        // Split loads and split store
        eb(0, 32'h104, 1'b1, 8'h0F, 64'd0);
        eb(0, 32'h108, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b010, 32'h106, 64'd0, 64'h6655_4433, 1'b0, 4);
        drain();
        eb(0, 32'h100, 1'b1, 8'h0F, 64'd0);
        eb(0, 32'h104, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b001, 32'h103, 64'd0, 64'h0000_1180, 1'b0, 4);
        drain();
        eb(0, 32'h104, 1'b0, 8'h0C, 64'h3344_0000);
        eb(0, 32'h108, 1'b0, 8'h03, 64'h0000_1122);
        issue(0, 1'b1, 3'b010, 32'h106, 64'h1122_3344, 64'd0, 1'b0, 3);
        drain();

        // Illegal funct3 for a 32-bit unit
        issue(0, 1'b0, 3'b011, 32'h100, 64'd0, 64'd0, 1'b1, 1);
        drain();
        issue(0, 1'b1, 3'b100, 32'h100, 64'h55, 64'd0, 1'b1, 1);
        drain();

        // Three stall cycles in BEAT0; ready changes just after posedge
        my_a = 1'b0;
        eb(0, 32'h200, 1'b0, 8'h08, 64'h5A00_0000);
        issue(0, 1'b1, 3'b000, 32'h203, 64'h5A, 64'd0, 1'b0, 5);
        repeat (3) @(posedge clk);
        #1 my_a = 1'b1;
        drain();

        // Reset while in BEAT1 of a split store
        eb(0, 32'h104, 1'b0, 8'h0C, 64'h3344_0000);
        eb(0, 32'h108, 1'b0, 8'h03, 64'h0000_1122);
        issue(0, 1'b1, 3'b010, 32'h106, 64'h1122_3344, 64'd0, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", 64'(cs_a), 64'd1);
        chk("midrst_rsp_valid", 64'(vl_a), 64'd0);
        chk("midrst_ready", 64'(rr_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", 64'(rr_a), 64'd1);
        chk("postrst_cs", 64'(cs_a), 64'd1);
        drain();
        eb(0, 32'h104, 1'b1, 8'h0F, 64'd0);
        issue(0, 1'b0, 3'b010, 32'h104, 64'd0, 64'h4433_2211, 1'b0, 3);
        drain();

        // XLEN 64 unit
        eb(1, 32'h0, 1'b1, 8'hFF, 64'd0);
        issue(1, 1'b0, 3'b110, 32'h4, 64'd0, 64'h0000_0000_F000_0001, 1'b0, 3);
        drain();
        eb(1, 32'h0, 1'b1, 8'hFF, 64'd0);
        issue(1, 1'b0, 3'b010, 32'h4, 64'd0, 64'hFFFF_FFFF_F000_0001, 1'b0, 3);
        drain();
        eb(1, 32'h0, 1'b1, 8'hFF, 64'd0);
        issue(1, 1'b0, 3'b011, 32'h0, 64'd0, 64'hF000_0001_DEAD_BEEF, 1'b0, 3);
        drain();
        eb(1, 32'h0, 1'b1, 8'hFF, 64'd0);
        issue(1, 1'b0, 3'b001, 32'h6, 64'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 3);
        drain();
        eb(1, 32'h8, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        issue(1, 1'b1, 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2);
        drain();
        eb(1, 32'h8, 1'b0, 8'hF0, 64'hCAFE_F00D_0000_0000);
        issue(1, 1'b1, 3'b010, 32'hC, 64'h0000_0000_CAFE_F00D, 64'd0, 1'b0, 2);
        drain();
        issue(1, 1'b0, 3'b111, 32'h0, 64'd0, 64'd0, 1'b1, 1);
        drain();
        issue(1, 1'b0, 3'b010, 32'h106, 64'd0, 64'd0, 1'b1, 1);
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Parametrised, sequential load/store unit between the core's execute stage and a single-port data memory. It generalises the load/store alignment logic to XLEN of 32 or 64 and adds sign/zero extension for every RISC-V load width. It also adds valid/ready request handshaking and a memory-side handshake with stall tolerance. Accesses that cross a memory-word boundary are split into two memory beats; when splitting is disabled they are flagged as errors.

## Interface
- XLEN, 32, data and memory-word width; legal values 32 or 64; NB = XLEN/8 byte lanes.
- ADDR_W, 32, byte-address width.
- MISALIGNED_EN, 1, 1 = split boundary-crossing accesses into two beats; 0 = report misaligned as error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept; high only in IDLE and only while rst is low.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address, already computed by the ALU.
- req_wdata  in  XLEN  store data, right-justified (rs2).
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3 or disallowed misalignment.
- mem_cs  out  1  chip select, active-low.
- mem_wr  out  1  0 = write, 1 = read; meaningful only when mem_cs = 0.
- mem_addr  out  ADDR_W  NB-aligned word address (low log2(NB) bits 0).
- mem_mask  out  NB  byte-lane enables for writes; all ones for reads.
- mem_wdata  out  XLEN  lane-positioned write data; unused lanes 0.
- mem_ready  in  1  memory accepts the beat presented this cycle.
- mem_rdata  in  XLEN  read data, valid exactly one cycle after an accepted read beat.

## Operation
- Size is from funct3[1:0]: 1, 2, 4 or 8 bytes. funct3[2] = 1 selects zero extension.
- Legal loads are 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With XLEN = 64, 011 LD and 110 LWU are also legal.
- Legal stores are 000–010, plus 011 when XLEN = 64.
- Anything else is illegal: accept, perform no memory access, rsp_err = 1.
- off = req_addr[log2(NB)-1:0]. A request is a split when off + size > NB.
- With MISALIGNED_EN = 0, any request where addr mod size ≠ 0 → rsp_err = 1 and no memory access.
- Store lane data: wide = {XLEN'0, req_wdata} << (8·off), 2·XLEN bits.
  - Beat0 data = wide[XLEN-1:0], mask = ((1<<size)-1) << off, truncated to NB bits.
  - Beat1 data = wide[2XLEN-1:XLEN], mask = the bits of the same shifted mask above NB.
- Beat addresses: beat0 = addr with low bits cleared; beat1 = beat0 + NB, wrapping modulo 2^ADDR_W.
- Load data: cat = {rd1, rd0} >> (8·off), where rd1 = 0 for non-split loads. Take the low size bytes, then sign- or zero-extend to XLEN.
- FSM states and transitions:
  - IDLE: on accept, latch the request. Illegal or error request → RESP; otherwise → BEAT0.
  - BEAT0: drive beat0. On mem_ready: split → BEAT1; load → WAIT; store → RESP.
  - BEAT1: drive beat1. On the first cycle in BEAT1, capture mem_rdata as rd0 (loads). On mem_ready: load → WAIT; store → RESP.
  - WAIT: capture mem_rdata as rd1 (split) or rd0 (non-split) → RESP.
  - RESP: rsp_valid = 1 with rsp_rdata and rsp_err from registers → IDLE.
- If mem_ready is low, hold the beat's addr, mask, wdata, cs and wr stable until it is accepted.
- mem_cs = 0 only in BEAT0 and BEAT1.

## Timing
- Request is accepted on the edge where req_valid && req_ready. Call that accept cycle c0.
- Latencies with mem_ready always high (rsp_valid cycle):
  - Aligned load: c3.
  - Aligned store: c2.
  - Split load: c4.
  - Split store: c3.
  - Error: c1.
- Each cycle mem_ready is low adds one cycle.
- Back-to-back: the next request can be accepted in the cycle after RESP; req_ready is 0 during RESP.
- All outputs are registered or decoded from state and latched registers. There is no combinational path from req_* to mem_* or rsp_*.
- Reset values: state IDLE, req_ready 0 during rst, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_cs 1, mem_wr 1, mem_addr 0, mem_mask 0, mem_wdata 0.
- Reset mid-operation: the next edge returns to IDLE. Any pending beat or response is dropped, and mem_cs = 1 from that edge on.
- rst and req_valid in the same cycle: the request is not accepted.

## Test plan
- XLEN = 32, LB at addr 0x103, memory word 0x80FF_1234 → one read beat at 0x100; rsp_rdata 0xFFFF_FF80 at c3; LBU → 0x0000_0080.
- SH at 0x202, wdata 0x0000_ABCD → beat at 0x200, mask 0b1100, mem_wdata 0xABCD_0000, mem_wr 0; rsp_valid at c2, rsp_err 0.
- LW at 0x106, MISALIGNED_EN = 1 → beats at 0x104 then 0x108. Words 0x4433_2211 and 0x8877_6655 give rsp_rdata 0x6655_4433 at c4. Same request with MISALIGNED_EN = 0 → rsp_err 1 at c1, mem_cs never low.
- XLEN = 64, LWU at 0x4, memory 0xF000_0001_xxxx_xxxx → rsp_rdata 0x0000_0000_F000_0001. SD at 0x8 → mask 0xFF. funct3 111 → rsp_err 1.
- mem_ready low for 3 cycles in BEAT0 → mem_addr, mask and wdata stable throughout; rsp delayed by 3 cycles.
- rst asserted in BEAT1 of a split store → mem_cs 1 on the next edge, no rsp_valid, req_ready 1 in the first cycle after rst deasserts.
